axi_write_cmd_arbiter: RTL and testbench



---
 rtl/axi_dma_pkg.sv | 25 ++
 rtl/axi_write_cmd_arbiter_rr_arbiter.sv | 45 ++++
 rtl/axi_write_cmd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi_write_cmd_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_pkg.sv
// Shared DMA types: burst encodings, write-arbiter FSM states and the
// transfer descriptor latched on each grant (addr, len, burst, size).
package axi_dma_pkg;

  localparam int ADDR_WD = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_WD-1:0] addr;
    logic [ADDR_WD-1:0] len;
    logic [1:0]         burst;
    logic [2:0]         size;
  } desc_t;

endpackage

// File: rtl/axi_write_cmd_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports: clk, rst (sync, active-high), req, advance -> grant_onehot, grant_idx.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  // Scan from the pointer upward, wrapping; first requester wins.
  always_comb begin
    found        = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap(int'(ptr) + i)]) begin
        found     = 1'b1;
        grant_idx = wrap(int'(ptr) + i);
      end
    end
    if (found) grant_onehot[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= wrap(int'(grant_idx) + 1);
    end
  end

endmodule

// File: rtl/axi_write_cmd_arbiter.sv
// Round-robin scheduler sharing one AXI write engine among NUM_CH channels.
// Ports: ch_req_* in / ch_req_ready, ch_done, ch_err out; w_cmd_* to engine;
// busy, grant_idx, timeout_err status. Optional watchdog: AXI_WR_ARB_TIMEOUT_EN.
module axi_write_cmd_arbiter
  import axi_dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_ADDR_WD = ADDR_WD,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [NUM_CH-1:0]             ch_req_valid,
  input  logic [NUM_CH*AXI_ADDR_WD-1:0] ch_req_addr,
  input  logic [NUM_CH*AXI_ADDR_WD-1:0] ch_req_len,
  input  logic [NUM_CH*2-1:0]           ch_req_burst,
  input  logic [NUM_CH*3-1:0]           ch_req_size,
  output logic [NUM_CH-1:0]             ch_req_ready,
  output logic [NUM_CH-1:0]             ch_done,
  output logic [NUM_CH-1:0]             ch_err,
  output logic                          w_cmd_valid,
  output logic [AXI_ADDR_WD-1:0]        w_cmd_addr,
  output logic [AXI_ID_WD-1:0]          w_cmd_id,
  output logic [1:0]                    w_cmd_burst,
  output logic [2:0]                    w_cmd_size,
  output logic [AXI_ADDR_WD-1:0]        w_cmd_len,
  input  logic                          w_cmd_ready,
  input  logic                          w_cmd_abort,
  output logic                          busy,
  output logic [$clog2(NUM_CH)-1:0]     grant_idx,
  output logic                          timeout_err
);

  localparam int IW = $clog2(NUM_CH);

  arb_state_e           state;
  desc_t                desc;
  desc_t                req_desc;
  logic [AXI_ID_WD-1:0] id_q;
  logic                 err;
  logic                 zero_len;
  logic                 grant_en;
  logic                 to_hit;
  logic [NUM_CH-1:0]    gnt_oh;
  logic [IW-1:0]        gnt;
  logic [NUM_CH-1:0]    own_oh;

  assign grant_en     = (state == S_IDLE) && (|ch_req_valid);
  assign ch_req_ready = grant_en ? gnt_oh : '0;
  assign own_oh       = NUM_CH'(1) << grant_idx;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .clk          (M_AXI_ACLK),
    .rst          (M_AXI_ARESET),
    .req          (ch_req_valid),
    .advance      (grant_en),
    .grant_onehot (gnt_oh),
    .grant_idx    (gnt)
  );

  always_comb begin
    req_desc.addr  = ch_req_addr[int'(gnt)*AXI_ADDR_WD +: AXI_ADDR_WD];
    req_desc.len   = ch_req_len[int'(gnt)*AXI_ADDR_WD +: AXI_ADDR_WD];
    req_desc.burst = ch_req_burst[int'(gnt)*2 +: 2];
    req_desc.size  = ch_req_size[int'(gnt)*3 +: 3];
  end

  assign w_cmd_addr  = desc.addr;
  assign w_cmd_len   = desc.len;
  assign w_cmd_burst = desc.burst;
  assign w_cmd_size  = desc.size;
  assign w_cmd_id    = id_q;

`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;
  logic          to_flag;
  logic          active;

  assign active      = (state == S_ISSUE) || (state == S_WAIT);
  // cnt equals cycles spent since ISSUE entry, so the limit fires on
  // the TIMEOUT_CYC-th cycle and DONE lands exactly TIMEOUT_CYC later.
  assign to_hit      = active && (cnt >= CW'(TIMEOUT_CYC - 1));
  assign timeout_err = to_flag;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      if (!active) cnt <= '0;
      else if (cnt != CW'(TIMEOUT_CYC)) cnt <= cnt + 1'b1;
      if (to_hit) to_flag <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state       <= S_IDLE;
      desc        <= '0;
      id_q        <= '0;
      err         <= 1'b0;
      zero_len    <= 1'b0;
      w_cmd_valid <= 1'b0;
      ch_done     <= '0;
      ch_err      <= '0;
      busy        <= 1'b0;
      grant_idx   <= '0;
    end else begin
      ch_done <= '0;
      ch_err  <= '0;
      unique case (state)
        S_IDLE: begin
          if (grant_en) begin
            desc        <= req_desc;
            id_q        <= AXI_ID_WD'(gnt);
            grant_idx   <= gnt;
            busy        <= 1'b1;
            // Zero length passes through ISSUE with valid held low.
            zero_len    <= (req_desc.len == '0);
            w_cmd_valid <= (req_desc.len != '0);
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (zero_len || to_hit) begin
            w_cmd_valid <= 1'b0;
            ch_done     <= own_oh;
            ch_err      <= own_oh;
            state       <= S_DONE;
          end else if (w_cmd_ready) begin
            w_cmd_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (to_hit) begin
            ch_done <= own_oh;
            ch_err  <= own_oh;
            state   <= S_DONE;
          end else if (w_cmd_abort) begin
            err <= 1'b1;
          end else if (w_cmd_ready || err) begin
            ch_done <= own_oh;
            ch_err  <= err ? own_oh : '0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          err      <= 1'b0;
          zero_len <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_cmd_arbiter.sv
// Directed self-checking bench for axi_write_cmd_arbiter.
// Covers reset, single transfer, fairness, abort, zero length, reset, timeout.
module tb_axi_write_cmd_arbiter;
  import axi_dma_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [127:0] req_len;
  logic [7:0]   req_burst;
  logic [11:0]  req_size;
  logic [3:0]   req_ready;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         cv;
  logic [31:0]  caddr;
  logic [1:0]   cid;
  logic [1:0]   cburst;
  logic [2:0]   csize;
  logic [31:0]  clen;
  logic         cready;
  logic         cabort;
  logic         busy;
  logic [1:0]   gidx;
  logic         to_err;

  int n_pass;
  int n_total;

  always #5 clk = ~clk;

  axi_write_cmd_arbiter #(
    .NUM_CH(4), .AXI_ID_WD(2), .AXI_ADDR_WD(32), .TIMEOUT_CYC(100)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .ch_req_valid (req_valid),
    .ch_req_addr  (req_addr),
    .ch_req_len   (req_len),
    .ch_req_burst (req_burst),
    .ch_req_size  (req_size),
    .ch_req_ready (req_ready),
    .ch_done      (done),
    .ch_err       (err),
    .w_cmd_valid  (cv),
    .w_cmd_addr   (caddr),
    .w_cmd_id     (cid),
    .w_cmd_burst  (cburst),
    .w_cmd_size   (csize),
    .w_cmd_len    (clen),
    .w_cmd_ready  (cready),
    .w_cmd_abort  (cabort),
    .busy         (busy),
    .grant_idx    (gidx),
    .timeout_err  (to_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int ch, input logic [31:0] a,
                          input logic [31:0] l, input logic [1:0] b,
                          input logic [2:0] s);
    req_addr[ch*32 +: 32] = a;
    req_len[ch*32 +: 32]  = l;
    req_burst[ch*2 +: 2]  = b;
    req_size[ch*3 +: 3]   = s;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    cready    = 1'b1;
    cabort    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({cv, busy, done, err, to_err} !== 11'd0)
      $display("FAIL reset_ctl: got %b want 0",
               {cv, busy, done, err, to_err});
    else n_pass++;
    n_total++;
    if ({gidx, cid, caddr, clen} !== 68'd0)
      $display("FAIL reset_data: got %h want 0", {gidx, cid, caddr, clen});
    else n_pass++;
    n_total++;
    if (req_ready !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    int ndone;
    int nerr;
    ndone = 0;
    nerr  = 0;
    set_desc(1, 32'h1000, 32'h400, BURST_INCR, 3'd2);
    req_valid = 4'b0010;
    cready    = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 4'b0010)
      $display("FAIL single_ready: got %b want 0010", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    n_total++;
    if ({cv, cid, clen, caddr, cburst, csize} !==
        {1'b1, 2'd1, 32'h400, 32'h1000, 2'b01, 3'd2})
      $display("FAIL single_cmd: got v%b id%0d len%h addr%h b%0d s%0d",
               cv, cid, clen, caddr, cburst, csize);
    else n_pass++;
    n_total++;
    if ({busy, gidx} !== 3'b101)
      $display("FAIL single_busy: got %b want 101", {busy, gidx});
    else n_pass++;
    step();
    cready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      ndone += int'(done[1]);
    end
    cready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ndone += int'(done[1]);
      nerr  += int'(|err);
    end
    n_total++;
    if (ndone !== 1)
      $display("FAIL single_done: got %0d pulses want 1", ndone);
    else n_pass++;
    n_total++;
    if (nerr !== 0)
      $display("FAIL single_err: got %0d err cycles want 0", nerr);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [1:0] ids[$];
    logic [1:0] exp_ids[6];
    int         ndone;
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ndone   = 0;
    do_reset();
    for (int c = 0; c < 4; c++)
      set_desc(c, 32'h100 * (c + 1), 32'h40, BURST_INCR, 3'd3);
    req_valid = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      step();
      if (cv) ids.push_back(cid);
      ndone += $countones(done);
    end
    req_valid = '0;
    n_total++;
    if (ids.size() !== 6)
      $display("FAIL fair_count: got %0d cmds want 6", ids.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < ids.size(); i++) begin
      n_total++;
      if (ids[i] !== exp_ids[i])
        $display("FAIL fair_order%0d: got %0d want %0d", i, ids[i],
                 exp_ids[i]);
      else n_pass++;
    end
    n_total++;
    if (ndone !== 6)
      $display("FAIL fair_done: got %0d want 6", ndone);
    else n_pass++;
    step();
    step();
  endtask

  task automatic test_abort();
    int early;
    early = 0;
    set_desc(2, 32'h3000, 32'h20, BURST_INCR, 3'd2);
    req_valid = 4'b0100;
    cready    = 1'b1;
    step();
    req_valid = '0;
    n_total++;
    if ({cv, cid} !== 3'b110)
      $display("FAIL abort_cmd: got v%b id%0d want v1 id2", cv, cid);
    else n_pass++;
    step();
    cready = 1'b0;
    cabort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      early += int'(|done);
    end
    cabort = 1'b0;
    cready = 1'b1;
    n_total++;
    if (early !== 0)
      $display("FAIL abort_early: got %0d done cycles want 0", early);
    else n_pass++;
    step();
    n_total++;
    if ({done, err} !== 8'b0100_0100)
      $display("FAIL abort_done: got d%b e%b want d0100 e0100", done, err);
    else n_pass++;
    set_desc(0, 32'h4000, 32'h10, BURST_FIXED, 3'd0);
    req_valid = 4'b0001;
    step();
    #1;
    n_total++;
    if (req_ready !== 4'b0001)
      $display("FAIL abort_next_rdy: got %b want 0001", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    step();
    step();
    n_total++;
    if ({done, err} !== 8'b0001_0000)
      $display("FAIL abort_next_done: got d%b e%b want d0001 e0000",
               done, err);
    else n_pass++;
    step();
  endtask

  task automatic test_zero_len();
    int vseen;
    vseen = 0;
    set_desc(3, 32'h5000, 32'h0, BURST_INCR, 3'd2);
    req_valid = 4'b1000;
    #1;
    n_total++;
    if (req_ready !== 4'b1000)
      $display("FAIL zero_ready: got %b want 1000", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    vseen += int'(cv);
    n_total++;
    if (done !== 4'b0000)
      $display("FAIL zero_early: got %b want 0000", done);
    else n_pass++;
    step();
    vseen += int'(cv);
    n_total++;
    if ({done, err} !== 8'b1000_1000)
      $display("FAIL zero_done: got d%b e%b want d1000 e1000", done, err);
    else n_pass++;
    step();
    vseen += int'(cv);
    n_total++;
    if (vseen !== 0)
      $display("FAIL zero_valid: got %0d valid cycles want 0", vseen);
    else n_pass++;
  endtask

  task automatic test_backpressure_reset();
    int unstable;
    int ndone;
    unstable = 0;
    ndone    = 0;
    set_desc(2, 32'h2000, 32'h80, BURST_WRAP, 3'd3);
    req_valid = 4'b0100;
    cready    = 1'b0;
    step();
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      if ({cv, cid, caddr, clen, cburst, csize} !==
          {1'b1, 2'd2, 32'h2000, 32'h80, 2'b10, 3'd3})
        unstable++;
      if (i < 4) step();
    end
    n_total++;
    if (unstable !== 0)
      $display("FAIL bp_stable: got %0d bad cycles want 0", unstable);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ndone += int'(|done);
    n_total++;
    if ({cv, busy, gidx, cid, caddr, clen} !== 70'd0)
      $display("FAIL bp_reset: got %h want 0",
               {cv, busy, gidx, cid, caddr, clen});
    else n_pass++;
    step();
    ndone += int'(|done);
    n_total++;
    if (ndone !== 0)
      $display("FAIL bp_nodone: got %0d want 0", ndone);
    else n_pass++;
    cready = 1'b1;
  endtask

  task automatic test_timeout();
    int k;
    k = 0;
    set_desc(1, 32'h6000, 32'h100, BURST_INCR, 3'd2);
    req_valid = 4'b0010;
    cready    = 1'b1;
    step();
    req_valid = '0;
    step();
    cready = 1'b0;
    k = 1;
    while (k < 150 && err == 4'b0000) begin
      step();
      k++;
    end
`ifdef AXI_WR_ARB_TIMEOUT_EN
    n_total++;
    if (k !== 100)
      $display("FAIL to_cycle: got %0d want 100", k);
    else n_pass++;
    n_total++;
    if ({done, err, to_err} !== 9'b0010_0010_1)
      $display("FAIL to_pulse: got d%b e%b t%b", done, err, to_err);
    else n_pass++;
    for (int i = 0; i < 5; i++) step();
    n_total++;
    if ({to_err, busy} !== 2'b10)
      $display("FAIL to_sticky: got %b want 10", {to_err, busy});
    else n_pass++;
`else
    n_total++;
    if ({k, to_err, busy} !== {32'd150, 1'b0, 1'b1})
      $display("FAIL no_to: got k%0d t%b b%b want 150 0 1", k, to_err, busy);
    else n_pass++;
`endif
    do_reset();
    n_total++;
    if ({to_err, busy} !== 2'b00)
      $display("FAIL to_clear: got %b want 00", {to_err, busy});
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    req_burst = '0;
    req_size  = '0;
    cready    = 1'b1;
    cabort    = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_zero_len();
    test_backpressure_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
